uart_core_cfg: RTL and testbench

Parametrised, runtime-configurable UART: programmable baud divisor, 5–8 data bits, optional even/odd parity, 1 or 2 stop bits, independent TX/RX FIFOs and sticky RX error flags. Successor to the fixed 8N1 UART top. It sits between a register/bus interface and the serial pins, and shares a single 16x-oversampling tick generator between TX and RX.

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/uart_core_cfg.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_uart_core_cfg.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the configurable UART.
package uart_pkg;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned MID_SAMPLE = 8;

   typedef enum logic [2:0] {
      TxIdle,
      TxStart,
      TxData,
      TxParity,
      TxStop1,
      TxStop2
   } tx_state_e;

   typedef enum logic [2:0] {
      RxIdle,
      RxStart,
      RxData,
      RxParity,
      RxStop
   } rx_state_e;

   // Index of the last data bit (width - 1), width = 5 + bits clipped to max_bits.
   function automatic logic [2:0] char_last(input logic [1:0] bits, input int unsigned max_bits);
      int unsigned last;
      last = 32'd4 + 32'(bits);
      if (last > max_bits - 1) last = max_bits - 1;
      return last[2:0];
   endfunction

   // XOR of data bits 0..last, inverted for odd parity.
   function automatic logic calc_parity(input logic [7:0] data, input logic [2:0] last,
                                        input logic odd);
      logic p;
      p = odd;
      for (int i = 0; i < 8; i++) begin
         if (i <= int'(last)) p ^= data[i];
      end
      return p;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO with occupancy output. Push while full is only
// accepted together with a pop; pop while empty is ignored.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      level_q, level_d;
   logic             do_wr, do_rd;

   assign full  = (level_q == (AW + 1)'(DEPTH));
   assign empty = (level_q == '0);
   assign level = level_q;
   assign do_wr = wr_en & (~full | rd_en);
   assign do_rd = rd_en & ~empty;
   // Empty reads as zero so the head never exposes stale storage.
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

   // Occupancy next-state.
   always_comb begin
      level_d = level_q;
      unique case ({do_wr, do_rd})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/uart_core_cfg.sv
// Runtime-configurable UART: shared 16x tick, TX/RX FSMs, FIFOs, sticky RX errors.
module uart_core_cfg
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned DIV_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DIV_WIDTH-1:0]          baud_div,
   input  logic [1:0]                    cfg_bits,
   input  logic                          cfg_par_en,
   input  logic                          cfg_par_odd,
   input  logic                          cfg_stop2,
   input  logic [DATA_BITS-1:0]          tx_data,
   input  logic                          tx_wr_en,
   output logic                          tx_full,
   output logic [$clog2(FIFO_DEPTH):0]   tx_level,
   output logic                          tx_busy,
   output logic                          tx,
   input  logic                          rx,
   input  logic                          rx_rd_en,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_empty,
   output logic [$clog2(FIFO_DEPTH):0]   rx_level,
   input  logic                          err_clr,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          overrun
);

   localparam logic [3:0] OS_LAST  = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] MID_LAST = 4'(MID_SAMPLE - 1);

   // ---------------- tick generator ----------------
   logic [DIV_WIDTH-1:0] div_cnt_q;
   logic                 tick;

   // >= rather than == so a smaller divisor written mid-count cannot stall the counter.
   assign tick = (div_cnt_q >= baud_div);

   // Free-running divider shared by TX and RX.
   always_ff @(posedge clk) begin
      if (rst)       div_cnt_q <= '0;
      else if (tick) div_cnt_q <= '0;
      else           div_cnt_q <= div_cnt_q + 1'b1;
   end

   logic [2:0] cfg_last;
   assign cfg_last = char_last(cfg_bits, DATA_BITS);

   // ---------------- TX ----------------
   logic [DATA_BITS-1:0] tx_fifo_data;
   logic                 tx_fifo_empty, tx_pop;
   tx_state_e            tx_state_q;
   logic [3:0]           tx_os_q;
   logic [2:0]           tx_bit_q, tx_last_q;
   logic [DATA_BITS-1:0] tx_shift_q;
   logic                 tx_par_en_q, tx_stop2_q, tx_par_q, tx_armed_q, tx_q, tx_busy_q;
   logic                 tx_bit_done;

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (tx_wr_en),
      .wr_data (tx_data),
      .rd_en   (tx_pop),
      .rd_data (tx_fifo_data),
      .full    (tx_full),
      .empty   (tx_fifo_empty),
      .level   (tx_level)
   );

   // Pop is tick-aligned so the start bit always begins on the following tick.
   assign tx_pop      = (tx_state_q == TxIdle) & tick & ~tx_fifo_empty;
   assign tx_bit_done = tick & tx_armed_q & (tx_os_q == OS_LAST);
   assign tx          = tx_q;
   assign tx_busy     = tx_busy_q;

   // TX frame sequencer; tx and tx_busy are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q  <= TxIdle;
         tx_os_q     <= '0;
         tx_bit_q    <= '0;
         tx_last_q   <= '0;
         tx_shift_q  <= '0;
         tx_par_en_q <= 1'b0;
         tx_stop2_q  <= 1'b0;
         tx_par_q    <= 1'b0;
         tx_armed_q  <= 1'b0;
         tx_q        <= 1'b1;
         tx_busy_q   <= 1'b0;
      end else begin
         // 4-bit oversample counter wraps to 0 on each bit boundary.
         if (tx_state_q != TxIdle && tx_armed_q && tick) tx_os_q <= tx_os_q + 1'b1;
         unique case (tx_state_q)
            TxIdle: begin
               if (tx_pop) begin
                  tx_shift_q  <= tx_fifo_data;
                  tx_last_q   <= cfg_last;
                  tx_par_q    <= calc_parity(8'(tx_fifo_data), cfg_last, cfg_par_odd);
                  tx_par_en_q <= cfg_par_en;
                  tx_stop2_q  <= cfg_stop2;
                  tx_os_q     <= '0;
                  tx_armed_q  <= 1'b0;
                  tx_busy_q   <= 1'b1;
                  tx_state_q  <= TxStart;
               end
            end
            TxStart: begin
               if (tick && !tx_armed_q) begin
                  tx_armed_q <= 1'b1;
                  tx_q       <= 1'b0;
               end else if (tx_bit_done) begin
                  tx_q       <= tx_shift_q[0];
                  tx_shift_q <= tx_shift_q >> 1;
                  tx_bit_q   <= '0;
                  tx_state_q <= TxData;
               end
            end
            TxData: begin
               if (tx_bit_done) begin
                  if (tx_bit_q == tx_last_q) begin
                     tx_q       <= tx_par_en_q ? tx_par_q : 1'b1;
                     tx_state_q <= tx_par_en_q ? TxParity : TxStop1;
                  end else begin
                     tx_bit_q   <= tx_bit_q + 1'b1;
                     tx_q       <= tx_shift_q[0];
                     tx_shift_q <= tx_shift_q >> 1;
                  end
               end
            end
            TxParity: begin
               if (tx_bit_done) begin
                  tx_q       <= 1'b1;
                  tx_state_q <= TxStop1;
               end
            end
            TxStop1: begin
               if (tx_bit_done) begin
                  if (tx_stop2_q) begin
                     tx_state_q <= TxStop2;
                  end else begin
                     tx_busy_q  <= 1'b0;
                     tx_state_q <= TxIdle;
                  end
               end
            end
            TxStop2: begin
               if (tx_bit_done) begin
                  tx_busy_q  <= 1'b0;
                  tx_state_q <= TxIdle;
               end
            end
            default: tx_state_q <= TxIdle;
         endcase
      end
   end

   // ---------------- RX ----------------
   logic                 rx_meta_q, rx_sync_q, rx_prev_q, rx_fall;
   rx_state_e            rx_state_q;
   logic [3:0]           rx_os_q;
   logic [2:0]           rx_bit_q, rx_last_q;
   logic [DATA_BITS-1:0] rx_shift_q;
   logic                 rx_par_en_q, rx_par_odd_q, rx_par_bit_q;
   logic                 rx_sample, rx_push, rx_fifo_full;
   logic                 set_frame, set_parity, set_overrun;

   // Two-flop synchroniser plus a delayed copy for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   assign rx_fall = rx_prev_q & ~rx_sync_q;

   // Sample point: tick 8 of the start bit, then every 16 ticks (mid-bit).
   always_comb begin
      rx_sample = 1'b0;
      if (tick) begin
         if (rx_state_q == RxStart)     rx_sample = (rx_os_q == MID_LAST);
         else if (rx_state_q != RxIdle) rx_sample = (rx_os_q == OS_LAST);
      end
   end

   assign rx_push     = (rx_state_q == RxStop) & rx_sample;
   assign set_frame   = rx_push & ~rx_sync_q;
   assign set_parity  = rx_push & rx_par_en_q &
                        (rx_par_bit_q != calc_parity(8'(rx_shift_q), rx_last_q, rx_par_odd_q));
   assign set_overrun = rx_push & rx_fifo_full;

   // RX frame sequencer.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_q   <= RxIdle;
         rx_os_q      <= '0;
         rx_bit_q     <= '0;
         rx_last_q    <= '0;
         rx_shift_q   <= '0;
         rx_par_en_q  <= 1'b0;
         rx_par_odd_q <= 1'b0;
         rx_par_bit_q <= 1'b0;
      end else begin
         if (rx_state_q != RxIdle && tick) rx_os_q <= rx_os_q + 1'b1;
         unique case (rx_state_q)
            RxIdle: begin
               if (rx_fall) begin
                  rx_os_q      <= '0;
                  rx_last_q    <= cfg_last;
                  rx_par_en_q  <= cfg_par_en;
                  rx_par_odd_q <= cfg_par_odd;
                  rx_shift_q   <= '0;
                  rx_state_q   <= RxStart;
               end
            end
            RxStart: begin
               if (rx_sample) begin
                  // Realign so later samples land mid-bit.
                  rx_os_q  <= '0;
                  rx_bit_q <= '0;
                  rx_state_q <= rx_sync_q ? RxIdle : RxData;
               end
            end
            RxData: begin
               if (rx_sample) begin
                  rx_shift_q[rx_bit_q] <= rx_sync_q;
                  if (rx_bit_q == rx_last_q) rx_state_q <= rx_par_en_q ? RxParity : RxStop;
                  else                       rx_bit_q   <= rx_bit_q + 1'b1;
               end
            end
            RxParity: begin
               if (rx_sample) begin
                  rx_par_bit_q <= rx_sync_q;
                  rx_state_q   <= RxStop;
               end
            end
            RxStop: begin
               if (rx_sample) rx_state_q <= RxIdle;
            end
            default: rx_state_q <= RxIdle;
         endcase
      end
   end

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (rx_push & ~rx_fifo_full),
      .wr_data (rx_shift_q),
      .rd_en   (rx_rd_en),
      .rd_data (rx_data),
      .full    (rx_fifo_full),
      .empty   (rx_empty),
      .level   (rx_level)
   );

   // Sticky error flags; a new error wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err  <= (frame_err  & ~err_clr) | set_frame;
         parity_err <= (parity_err & ~err_clr) | set_parity;
         overrun    <= (overrun    & ~err_clr) | set_overrun;
      end
   end

endmodule

// File: tb/tb_uart_core_cfg.sv
// Directed bench for uart_core_cfg with a byte scoreboard.
module tb_uart_core_cfg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] baud_div = '0;
   logic [1:0]  cfg_bits = 2'd3;
   logic        cfg_par_en = 1'b0, cfg_par_odd = 1'b0, cfg_stop2 = 1'b0;
   logic [7:0]  tx_data = '0;
   logic        tx_wr_en = 1'b0, rx_rd_en = 1'b0, err_clr = 1'b0;
   logic        rx_drv = 1'b1, loop_en = 1'b0;
   logic        rx_line;
   logic        tx_full, tx_busy, tx_w, rx_empty, frame_err, parity_err, overrun;
   logic [4:0]  tx_level, rx_level;
   logic [7:0]  rx_data;

   int          vectors = 0;
   int          miscompares = 0;
   int          max_tx_lvl = 0;
   logic [7:0]  exp_q [$];

   assign rx_line = loop_en ? tx_w : rx_drv;

   always #5 clk = ~clk;

   uart_core_cfg #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .baud_div   (baud_div),
      .cfg_bits   (cfg_bits),
      .cfg_par_en (cfg_par_en),
      .cfg_par_odd(cfg_par_odd),
      .cfg_stop2  (cfg_stop2),
      .tx_data    (tx_data),
      .tx_wr_en   (tx_wr_en),
      .tx_full    (tx_full),
      .tx_level   (tx_level),
      .tx_busy    (tx_busy),
      .tx         (tx_w),
      .rx         (rx_line),
      .rx_rd_en   (rx_rd_en),
      .rx_data    (rx_data),
      .rx_empty   (rx_empty),
      .rx_level   (rx_level),
      .err_clr    (err_clr),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun)
   );

   always @(negedge clk) if (int'(tx_level) > max_tx_lvl) max_tx_lvl = int'(tx_level);

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_tx(input logic [7:0] d);
      tx_data  = d;
      tx_wr_en = 1'b1;
      @(negedge clk);
      tx_wr_en = 1'b0;
   endtask

   task automatic wait_rx(input int budget);
      int n = 0;
      while (rx_empty && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("rx_arrive", rx_empty, 0);
   endtask

   task automatic read_rx(input string tag);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         check("sb_underflow", 1, 0);
      end else begin
         e = exp_q.pop_front();
         check(tag, rx_data, e);
      end
      rx_rd_en = 1'b1;
      @(negedge clk);
      rx_rd_en = 1'b0;
   endtask

   // Drive one frame on rx; flip corrupts parity, stop_v sets the stop bit level.
   task automatic send_rx(input logic [7:0] d, input int nbits, input bit pen, input bit podd,
                          input bit flip, input bit stop_v, input int bt);
      logic p;
      p = podd ^ flip;
      rx_drv = 1'b0;
      clk_n(bt);
      for (int i = 0; i < nbits; i++) begin
         rx_drv = d[i];
         p ^= d[i];
         clk_n(bt);
      end
      if (pen) begin
         rx_drv = p;
         clk_n(bt);
      end
      rx_drv = stop_v;
      clk_n(bt);
      rx_drv = 1'b1;
      if (!stop_v) clk_n(bt);
   endtask

   // Decode one 8N1 frame from tx; returns at mid stop bit.
   task automatic get_tx(input int bt, output logic [7:0] d);
      int n = 0;
      d = '0;
      while (tx_w && n < 4 * bt + 200) begin
         @(negedge clk);
         n++;
      end
      check("tx_start_seen", tx_w, 0);
      clk_n(bt / 2);
      for (int i = 0; i < 8; i++) begin
         clk_n(bt);
         d[i] = tx_w;
      end
      clk_n(bt);
      check("tx_stop_high", tx_w, 1);
   endtask

   initial begin
      logic [9:0] fb;
      logic [7:0] got, e;
      int         n;

      // ---- reset state ----
      clk_n(3);
      check("rst_tx", tx_w, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_full", tx_full, 0);
      check("rst_rx_empty", rx_empty, 1);
      check("rst_tx_level", tx_level, 0);
      check("rst_rx_level", rx_level, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_flags", {frame_err, parity_err, overrun}, 0);
      rst = 1'b0;
      clk_n(2);

      // ---- TX 8N1 at baud_div 0: exact bit timing ----
      push_tx(8'h55);
      n = 0;
      while (tx_w && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("tx8n1_fall", tx_w, 0);
      fb = {1'b1, 8'h55, 1'b0};
      for (int k = 0; k < 160; k++) begin
         check("tx8n1_bit", tx_w, fb[k / 16]);
         if (k == 159) check("tx8n1_busy_hi", tx_busy, 1);
         @(negedge clk);
      end
      check("tx8n1_busy_fall", tx_busy, 0);
      check("tx8n1_idle", tx_w, 1);

      // ---- loopback 7E2 then 5O1 ----
      loop_en = 1'b1;
      baud_div = 16'd3;
      cfg_bits = 2'd2; cfg_par_en = 1'b1; cfg_par_odd = 1'b0; cfg_stop2 = 1'b1;
      exp_q.push_back(8'h41);
      push_tx(8'h41);
      wait_rx(3000);
      read_rx("lb7e2_data");
      check("lb7e2_flags", {frame_err, parity_err, overrun}, 0);
      n = 0;
      while (tx_busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("lb7e2_tx_done", tx_busy, 0);
      cfg_bits = 2'd0; cfg_par_odd = 1'b1; cfg_stop2 = 1'b0;
      exp_q.push_back(8'h15);
      push_tx(8'h15);
      wait_rx(3000);
      read_rx("lb5o1_data");
      check("lb5o1_flags", {frame_err, parity_err, overrun}, 0);
      n = 0;
      while (tx_busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      loop_en = 1'b0;
      clk_n(100);

      // ---- parity error then framing error (8E1, baud_div 3) ----
      cfg_bits = 2'd3; cfg_par_en = 1'b1; cfg_par_odd = 1'b0; cfg_stop2 = 1'b0;
      exp_q.push_back(8'hA5);
      send_rx(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1, 64);
      check("err_par_set", parity_err, 1);
      check("err_frame_clear", frame_err, 0);
      exp_q.push_back(8'h3C);
      send_rx(8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b0, 64);
      check("err_frame_set", frame_err, 1);
      check("err_par_sticky", parity_err, 1);
      check("err_level", rx_level, 2);
      read_rx("err_byte0");
      read_rx("err_byte1");
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("err_cleared", {frame_err, parity_err, overrun}, 0);

      // ---- TX FIFO bound: 17 pushes, TX idle waiting for the first tick ----
      cfg_par_en = 1'b0;
      rst = 1'b1;
      baud_div = 16'd100;
      clk_n(2);
      rst = 1'b0;
      tx_wr_en = 1'b1;
      for (int i = 0; i < 17; i++) begin
         tx_data = 8'(8'h20 + i);
         if (i < 16) exp_q.push_back(8'(8'h20 + i));
         @(negedge clk);
         check("bound_level", tx_level, (i < 16) ? i + 1 : 16);
         check("bound_full", tx_full, (i >= 15) ? 1 : 0);
      end
      tx_wr_en = 1'b0;
      baud_div = 16'd0;
      for (int i = 0; i < 16; i++) begin
         get_tx(16, got);
         e = exp_q.pop_front();
         check("bound_byte", got, e);
      end
      clk_n(400);
      check("bound_no_17th", {tx_busy, tx_w}, 2'b01);
      check("bound_drained", tx_level, 0);
      check("bound_max_level", max_tx_lvl, 16);

      // ---- RX overrun: 17 frames, no reads (8N1, baud_div 0) ----
      for (int i = 0; i < 17; i++) begin
         if (i < 16) exp_q.push_back(8'(8'h80 + i));
         send_rx(8'(8'h80 + i), 8, 1'b0, 1'b0, 1'b0, 1'b1, 16);
      end
      clk_n(20);
      check("ovr_flag", overrun, 1);
      check("ovr_level", rx_level, 16);
      check("ovr_other_flags", {frame_err, parity_err}, 0);
      for (int i = 0; i < 16; i++) read_rx("ovr_byte");
      check("ovr_empty", rx_empty, 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("ovr_cleared", overrun, 0);

      // ---- 5-clock glitch is rejected ----
      rx_drv = 1'b0;
      clk_n(5);
      rx_drv = 1'b1;
      clk_n(200);
      check("glitch_empty", rx_empty, 1);
      check("glitch_level", rx_level, 0);
      check("glitch_flags", {frame_err, parity_err, overrun}, 0);

      // ---- reset mid-TX frame ----
      send_rx(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 16);
      clk_n(10);
      check("rstmid_rx_level", rx_level, 1);
      push_tx(8'h00);
      push_tx(8'h00);
      push_tx(8'h00);
      n = 0;
      while (tx_w && n < 100) begin
         @(negedge clk);
         n++;
      end
      clk_n(40);
      check("rstmid_pre_tx", tx_w, 0);
      rst = 1'b1;
      @(negedge clk);
      check("rstmid_tx", tx_w, 1);
      check("rstmid_tx_level", tx_level, 0);
      check("rstmid_rx_level", rx_level, 0);
      check("rstmid_busy", tx_busy, 0);
      rst = 1'b0;
      clk_n(5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
